// File: rtl/pipe_ctrl_if.sv
// ID-stage instruction fields into the pipeline control unit, and the control/hazard outputs it produces.
// The master side drives the ID fields; the slave side (the control unit) drives everything else.
interface pipe_ctrl_if #(
    parameter int OP_W  = 6,
    parameter int REG_W = 5,
    parameter int ALU_W = 2,
    parameter int CNT_W = 16
);
    logic [OP_W-1:0]    op_i;
    logic [REG_W-1:0]   rs_i;
    logic [REG_W-1:0]   rt_i;
    logic [REG_W-1:0]   rd_i;
    logic               is_equal_i;
    logic [1:0]         pc_sel_o;
    logic               pc_we_o;
    logic               ifid_we_o;
    logic               ifid_flush_o;
    logic [ALU_W+1:0]   ex_ctrl_o;
    logic [1:0]         mem_ctrl_o;
    logic [1:0]         wb_ctrl_o;
    logic [REG_W-1:0]   wb_reg_o;
    logic [1:0]         fwd_a_o;
    logic [1:0]         fwd_b_o;
    logic               illegal_o;
    logic [CNT_W-1:0]   stall_cnt_o;

    modport master (
        output op_i, rs_i, rt_i, rd_i, is_equal_i,
        input  pc_sel_o, pc_we_o, ifid_we_o, ifid_flush_o, ex_ctrl_o, mem_ctrl_o,
               wb_ctrl_o, wb_reg_o, fwd_a_o, fwd_b_o, illegal_o, stall_cnt_o
    );

    modport slave (
        input  op_i, rs_i, rt_i, rd_i, is_equal_i,
        output pc_sel_o, pc_we_o, ifid_we_o, ifid_flush_o, ex_ctrl_o, mem_ctrl_o,
               wb_ctrl_o, wb_reg_o, fwd_a_o, fwd_b_o, illegal_o, stall_cnt_o
    );
endinterface

// File: rtl/pipeline_control.sv
// 5-stage pipeline decode/hazard/redirect control; define PIPE_CTRL_FWD_EN for EX operand forwarding.
// Controls appear 1/2/3 cycles after decode; a stall holds PC and IF/ID and bubbles ID/EX, and beats redirects.
module pipeline_control #(
    parameter int OP_W  = 6,
    parameter int REG_W = 5,
    parameter int ALU_W = 2,
    parameter int CNT_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    pipe_ctrl_if.slave  bus
);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'h01);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'h03);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h10);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h11);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h2B);

    // ALU-op: address add, compare subtract, or R-type (ALU resolves the function from its own opcode copy)
    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_RT  = ALU_W'(2);

    logic [ALU_W+1:0]   dec_ex;
    logic [1:0]         dec_mem, dec_wb;
    logic [REG_W-1:0]   dec_dst;
    logic               use_rs, use_rt, is_beq, is_j, legal;

    logic [ALU_W+1:0]   idex_ex_q, idex_ex_d;
    logic [1:0]         idex_mem_q, idex_mem_d, idex_wb_q, idex_wb_d;
    logic [REG_W-1:0]   idex_dst_q, idex_dst_d;
    logic [1:0]         exmem_mem_q, exmem_wb_q, memwb_wb_q;
    logic [REG_W-1:0]   exmem_dst_q, memwb_dst_q;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               idex_we, exmem_we, idex_hit, exmem_hit;
    logic               stall_raw, stall, taken;

    always_comb begin
        dec_ex  = '0;
        dec_mem = 2'b00;
        dec_wb  = 2'b00;
        dec_dst = '0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        is_beq  = 1'b0;
        is_j    = 1'b0;
        legal   = 1'b1;
        case (bus.op_i)
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR: begin
                dec_ex  = {ALU_RT, 1'b0, 1'b1};
                dec_wb  = 2'b01;
                dec_dst = bus.rd_i;
                use_rs  = 1'b1;
                use_rt  = 1'b1;
            end
            OP_ADDI: begin
                dec_ex  = {ALU_ADD, 1'b1, 1'b0};
                dec_wb  = 2'b01;
                dec_dst = bus.rt_i;
                use_rs  = 1'b1;
            end
            OP_LW: begin
                dec_ex  = {ALU_ADD, 1'b1, 1'b0};
                dec_mem = 2'b10;
                dec_wb  = 2'b11;
                dec_dst = bus.rt_i;
                use_rs  = 1'b1;
            end
            OP_SW: begin
                dec_ex  = {ALU_ADD, 1'b1, 1'b0};
                dec_mem = 2'b11;
                use_rs  = 1'b1;
                use_rt  = 1'b1;
            end
            OP_BEQ: begin
                dec_ex  = {ALU_SUB, 1'b0, 1'b0};
                use_rs  = 1'b1;
                use_rt  = 1'b1;
                is_beq  = 1'b1;
            end
            OP_J:    is_j  = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign idex_we   = idex_wb_q[0] && (idex_dst_q != '0);
    assign exmem_we  = exmem_wb_q[0] && (exmem_dst_q != '0);
    assign idex_hit  = idex_we && ((use_rs && idex_dst_q == bus.rs_i) || (use_rt && idex_dst_q == bus.rt_i));
    assign exmem_hit = exmem_we && ((use_rs && exmem_dst_q == bus.rs_i) || (use_rt && exmem_dst_q == bus.rt_i));

`ifdef PIPE_CTRL_FWD_EN
    logic [REG_W-1:0] idex_rs_q, idex_rt_q;
    logic             memwb_we, load_use, beq_hz;

    assign memwb_we = memwb_wb_q[0] && (memwb_dst_q != '0);
    assign load_use = (idex_mem_q == 2'b10) && (idex_dst_q != '0) &&
                      ((idex_dst_q == bus.rs_i) || (use_rt && idex_dst_q == bus.rt_i));
    // The comparator sits in ID, so a branch cannot take a forwarded EX result or a load still in MEM
    assign beq_hz   = is_beq && (idex_hit || ((exmem_mem_q == 2'b10) && exmem_hit));
    assign stall_raw = load_use || beq_hz;

    always_comb begin
        bus.fwd_a_o = 2'b00;
        bus.fwd_b_o = 2'b00;
        if (exmem_we && exmem_dst_q == idex_rs_q)      bus.fwd_a_o = 2'b10;
        else if (memwb_we && memwb_dst_q == idex_rs_q) bus.fwd_a_o = 2'b01;
        if (exmem_we && exmem_dst_q == idex_rt_q)      bus.fwd_b_o = 2'b10;
        else if (memwb_we && memwb_dst_q == idex_rt_q) bus.fwd_b_o = 2'b01;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idex_rs_q <= '0;
            idex_rt_q <= '0;
        end else begin
            idex_rs_q <= (!stall && use_rs) ? bus.rs_i : '0;
            idex_rt_q <= (!stall && use_rt) ? bus.rt_i : '0;
        end
    end
`else
    assign stall_raw   = idex_hit || exmem_hit;
    assign bus.fwd_a_o = 2'b00;
    assign bus.fwd_b_o = 2'b00;
`endif

    // Gate with reset so an instruction sitting in ID cannot stall or redirect while reset is held
    assign stall = rst_n_i && stall_raw;
    assign taken = rst_n_i && !stall_raw && (is_j || (is_beq && bus.is_equal_i));

    assign idex_ex_d   = stall ? '0 : dec_ex;
    assign idex_mem_d  = stall ? 2'b00 : dec_mem;
    assign idex_wb_d   = stall ? 2'b00 : dec_wb;
    assign idex_dst_d  = stall ? '0 : dec_dst;
    assign illegal_d   = illegal_q || !legal;
    assign stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idex_ex_q   <= '0;
            idex_mem_q  <= 2'b00;
            idex_wb_q   <= 2'b00;
            idex_dst_q  <= '0;
            exmem_mem_q <= 2'b00;
            exmem_wb_q  <= 2'b00;
            exmem_dst_q <= '0;
            memwb_wb_q  <= 2'b00;
            memwb_dst_q <= '0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            idex_ex_q   <= idex_ex_d;
            idex_mem_q  <= idex_mem_d;
            idex_wb_q   <= idex_wb_d;
            idex_dst_q  <= idex_dst_d;
            exmem_mem_q <= idex_mem_q;
            exmem_wb_q  <= idex_wb_q;
            exmem_dst_q <= idex_dst_q;
            memwb_wb_q  <= exmem_wb_q;
            memwb_dst_q <= exmem_dst_q;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_we_o      = !stall;
    assign bus.ifid_we_o    = !stall;
    assign bus.ifid_flush_o = taken;
    assign bus.pc_sel_o     = taken ? (is_beq ? 2'b11 : 2'b10) : 2'b00;
    assign bus.ex_ctrl_o    = idex_ex_q;
    assign bus.mem_ctrl_o   = exmem_mem_q;
    assign bus.wb_ctrl_o    = memwb_wb_q;
    assign bus.wb_reg_o     = memwb_dst_q;
    assign bus.illegal_o    = illegal_q;
    assign bus.stall_cnt_o  = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_control.sv
// Directed checks of pipeline_control: reset, decode shift, load-use, branch/jump redirect, RAW, r0, illegal op.
module tb_pipeline_control;
    localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_ADDI = 6'h08, OP_J = 6'h10;
    localparam logic [5:0] OP_BEQ = 6'h11, OP_LW = 6'h23, OP_BAD = 6'h3F;

`ifdef PIPE_CTRL_FWD_EN
    localparam int CNT_AFTER_D = 2;
`else
    localparam int CNT_AFTER_D = 6;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_asrt = 0;
    int   n_fail = 0;

    pipe_ctrl_if #(.OP_W(6), .REG_W(5), .ALU_W(2), .CNT_W(16)) bus ();

    pipeline_control #(.OP_W(6), .REG_W(5), .ALU_W(2), .CNT_W(16)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic eq);
        bus.op_i = op; bus.rs_i = rs; bus.rt_i = rt; bus.rd_i = rd; bus.is_equal_i = eq;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Not-taken BEQ r0,r0 is a filler with no write, no memory access and no hazard
    task automatic drain(input int n);
        issue(OP_BEQ, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (n) tick();
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_pc_we"},   32'(bus.pc_we_o), 1);
        chk({pfx, "_ifid_we"}, 32'(bus.ifid_we_o), 1);
        chk({pfx, "_flush"},   32'(bus.ifid_flush_o), 0);
        chk({pfx, "_pc_sel"},  32'(bus.pc_sel_o), 0);
        chk({pfx, "_ex"},      32'(bus.ex_ctrl_o), 0);
        chk({pfx, "_mem"},     32'(bus.mem_ctrl_o), 0);
        chk({pfx, "_wb"},      32'(bus.wb_ctrl_o), 0);
        chk({pfx, "_wb_reg"},  32'(bus.wb_reg_o), 0);
        chk({pfx, "_illegal"}, 32'(bus.illegal_o), 0);
        chk({pfx, "_cnt"},     32'(bus.stall_cnt_o), 0);
        chk({pfx, "_fwd_a"},   32'(bus.fwd_a_o), 0);
        chk({pfx, "_fwd_b"},   32'(bus.fwd_b_o), 0);
    endtask

    initial begin
        // Reset held with a taken jump in ID: no redirect may leak out
        issue(OP_J, 5'd0, 5'd0, 5'd0, 1'b0);
        chk_reset_outputs("rst");
        tick();
        rst_n = 1'b1;

        // LW r2 then ADD r3,r2,r4
        issue(OP_LW, 5'd1, 5'd2, 5'd0, 1'b0);
        chk("lw_pc_we", 32'(bus.pc_we_o), 1);
        tick();
        issue(OP_ADD, 5'd2, 5'd4, 5'd3, 1'b0);
        chk("lu_pc_we", 32'(bus.pc_we_o), 0);
        chk("lu_ifid_we", 32'(bus.ifid_we_o), 0);
        chk("lu_ex_lw", 32'(bus.ex_ctrl_o), 4'b0010);
        tick();
        chk("lu_bubble", 32'(bus.ex_ctrl_o), 0);
        chk("lu_mem_lw", 32'(bus.mem_ctrl_o), 2'b10);
        chk("lu_cnt1", 32'(bus.stall_cnt_o), 1);
`ifdef PIPE_CTRL_FWD_EN
        chk("lu_resume", 32'(bus.pc_we_o), 1);
        tick();
        chk("lu_add_ex", 32'(bus.ex_ctrl_o), 4'b1001);
        chk("lu_fwd_a", 32'(bus.fwd_a_o), 2'b01);
        chk("lu_fwd_b", 32'(bus.fwd_b_o), 2'b00);
        chk("lu_cnt_end", 32'(bus.stall_cnt_o), 1);
`else
        chk("raw_exmem_stall", 32'(bus.pc_we_o), 0);
        tick();
        chk("raw_resume", 32'(bus.pc_we_o), 1);
        chk("raw_bubble2", 32'(bus.ex_ctrl_o), 0);
        chk("raw_fwd_a", 32'(bus.fwd_a_o), 0);
        chk("lu_cnt_end", 32'(bus.stall_cnt_o), 2);
`endif
        chk("lu_wb_lw", 32'(bus.wb_ctrl_o), 2'b11);
        chk("lu_wb_reg", 32'(bus.wb_reg_o), 2);
        tick();
        drain(3);

        // Branch taken / not taken, then jump
        issue(OP_BEQ, 5'd5, 5'd6, 5'd0, 1'b1);
        chk("beq_t_sel", 32'(bus.pc_sel_o), 2'b11);
        chk("beq_t_flush", 32'(bus.ifid_flush_o), 1);
        chk("beq_t_pc_we", 32'(bus.pc_we_o), 1);
        tick();
        issue(OP_BEQ, 5'd5, 5'd6, 5'd0, 1'b0);
        chk("beq_nt_sel", 32'(bus.pc_sel_o), 0);
        chk("beq_nt_flush", 32'(bus.ifid_flush_o), 0);
        tick();
        issue(OP_J, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("j_sel", 32'(bus.pc_sel_o), 2'b10);
        chk("j_flush", 32'(bus.ifid_flush_o), 1);
        tick();
        drain(3);

        // ADD r1 then SUB r5,r1,r1
        issue(OP_ADD, 5'd7, 5'd8, 5'd1, 1'b0);
        tick();
        issue(OP_SUB, 5'd1, 5'd1, 5'd5, 1'b0);
`ifdef PIPE_CTRL_FWD_EN
        chk("sub_pc_we", 32'(bus.pc_we_o), 1);
        tick();
        chk("sub_fwd_a", 32'(bus.fwd_a_o), 2'b10);
        chk("sub_fwd_b", 32'(bus.fwd_b_o), 2'b10);
`else
        chk("sub_stall1", 32'(bus.pc_we_o), 0);
        tick();
        chk("sub_stall2", 32'(bus.pc_we_o), 0);
        tick();
        chk("sub_resume", 32'(bus.pc_we_o), 1);
        tick();
        chk("sub_fwd_a", 32'(bus.fwd_a_o), 0);
        chk("sub_fwd_b", 32'(bus.fwd_b_o), 0);
`endif
        drain(3);

        // ADD r9 then taken BEQ on r9: stall wins over redirect
        issue(OP_ADD, 5'd7, 5'd8, 5'd9, 1'b0);
        tick();
        issue(OP_BEQ, 5'd9, 5'd0, 5'd0, 1'b1);
        chk("bhz_pc_we", 32'(bus.pc_we_o), 0);
        chk("bhz_sel", 32'(bus.pc_sel_o), 0);
        chk("bhz_flush", 32'(bus.ifid_flush_o), 0);
        tick();
`ifndef PIPE_CTRL_FWD_EN
        chk("bhz_stall2", 32'(bus.pc_we_o), 0);
        chk("bhz_sel2", 32'(bus.pc_sel_o), 0);
        tick();
`endif
        chk("bhz_go_sel", 32'(bus.pc_sel_o), 2'b11);
        chk("bhz_go_flush", 32'(bus.ifid_flush_o), 1);
        tick();
        drain(3);

        // ADD writing r0, then a reader of r0
        issue(OP_ADD, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        issue(OP_SUB, 5'd0, 5'd0, 5'd4, 1'b0);
        chk("r0_pc_we", 32'(bus.pc_we_o), 1);
        tick();
        chk("r0_fwd_a", 32'(bus.fwd_a_o), 0);
        chk("r0_fwd_b", 32'(bus.fwd_b_o), 0);
        chk("cnt_total", 32'(bus.stall_cnt_o), 32'(CNT_AFTER_D));
        drain(3);

        // Undefined opcode
        issue(OP_BAD, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("ill_before", 32'(bus.illegal_o), 0);
        tick();
        chk("ill_set", 32'(bus.illegal_o), 1);
        chk("ill_ex", 32'(bus.ex_ctrl_o), 0);
        issue(OP_BEQ, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        chk("ill_mem", 32'(bus.mem_ctrl_o), 0);
        tick();
        chk("ill_wb", 32'(bus.wb_ctrl_o), 0);
        chk("ill_sticky", 32'(bus.illegal_o), 1);
        drain(3);

        // Reset in the middle of a load-use stall
        issue(OP_LW, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        issue(OP_ADD, 5'd2, 5'd4, 5'd3, 1'b0);
        chk("mid_stall", 32'(bus.pc_we_o), 0);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        tick();
        rst_n = 1'b1;
        issue(OP_ADDI, 5'd1, 5'd7, 5'd0, 1'b0);
        chk("addi_pc_we", 32'(bus.pc_we_o), 1);
        chk("addi_flush", 32'(bus.ifid_flush_o), 0);
        tick();
        chk("addi_ex", 32'(bus.ex_ctrl_o), 4'b0010);
        tick();
        tick();
        chk("addi_wb", 32'(bus.wb_ctrl_o), 2'b01);
        chk("addi_wb_reg", 32'(bus.wb_reg_o), 7);
        chk("addi_cnt", 32'(bus.stall_cnt_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
